// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the multiply/divide operand feeder.
package mult_div_pkg;
  localparam int WORD_W = 26;
  localparam int PAIRS  = WORD_W / 2;
  localparam int CNT_W  = $clog2(WORD_W);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
endpackage

// File: rtl/md_radix4_recode.sv
// Radix-4 recoding of one bit pair plus incoming carry into a {-2..2} digit.
module md_radix4_recode
  import mult_div_pkg::*;
(
  input  logic [1:0] pair,
  input  logic       carry_in,
  input  logic       is_top,
  output digit_t     dig,
  output logic       carry_out
);
  logic [2:0] sum;

  // The top pair is sign-extended, so its sums land on 6/7 (-2/-1) instead of 3/4.
  assign sum = (is_top ? {pair[1], pair} : {1'b0, pair}) + {2'b00, carry_in};

  always_comb begin
    dig       = '0;
    carry_out = 1'b0;
    case (sum)
      3'd1: dig.one = 1'b1;
      3'd2: dig.two = 1'b1;
      3'd3: begin dig.neg = 1'b1; dig.one = 1'b1; carry_out = !is_top; end
      3'd4: carry_out = !is_top;
      3'd6: begin dig.neg = 1'b1; dig.two = 1'b1; end
      3'd7: begin dig.neg = 1'b1; dig.one = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/mult_div_feed.sv
// Operand feeder: recoded radix-4 digits (multiply) or MSB-first bits (divide).
module mult_div_feed
  import mult_div_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              LOAD,
  input  logic [WORD_W-1:0] LD_WORD,
  input  logic              LD_DIV,
  input  logic              STEP,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DIG_NEG,
  output logic              DIG_ONE,
  output logic              DIG_TWO,
  output logic              DONE,
  output logic              LOAD_ERR
);
  state_t            state, state_n;
  logic              mode, mode_n;
  logic [WORD_W-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              cin, cin_n, cout;
  logic              done_n, err_n, last;
  digit_t            nxt_dig;
  logic              nxt_cout;

  assign last = (mode == MODE_MUL) ? (cnt == CNT_W'(PAIRS - 1)) : (cnt == CNT_W'(WORD_W - 1));

  always_comb begin
    state_n = state;
    mode_n  = mode;
    sreg_n  = sreg;
    cnt_n   = cnt;
    cin_n   = cin;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (ABORT) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (LOAD) begin
        state_n = SEND;
        mode_n  = LD_DIV;
        sreg_n  = LD_WORD;
        cnt_n   = '0;
        cin_n   = 1'b0;
      end
    end else begin
      err_n = LOAD;
      if (STEP) begin
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (mode == MODE_MUL) begin
            sreg_n = sreg >> 2;
            cin_n  = cout;
          end else begin
            sreg_n = sreg << 1;
            cin_n  = 1'b0;
          end
        end
      end
    end
  end

  // Recode the digit that will be on the outputs next cycle, so outputs stay registered.
  md_radix4_recode u_recode (
    .pair      (sreg_n[1:0]),
    .carry_in  (cin_n),
    .is_top    (cnt_n == CNT_W'(PAIRS - 1)),
    .dig       (nxt_dig),
    .carry_out (nxt_cout)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      mode     <= MODE_MUL;
      sreg     <= '0;
      cnt      <= '0;
      cin      <= 1'b0;
      cout     <= 1'b0;
      BUSY     <= 1'b0;
      DIG_NEG  <= 1'b0;
      DIG_ONE  <= 1'b0;
      DIG_TWO  <= 1'b0;
      DONE     <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      state    <= state_n;
      mode     <= mode_n;
      sreg     <= sreg_n;
      cnt      <= cnt_n;
      cin      <= cin_n;
      cout     <= nxt_cout & (mode_n == MODE_MUL);
      BUSY     <= (state_n == SEND);
      DONE     <= done_n;
      LOAD_ERR <= err_n;
      if (state_n == SEND && mode_n == MODE_MUL) begin
        {DIG_NEG, DIG_ONE, DIG_TWO} <= nxt_dig;
      end else if (state_n == SEND) begin
        {DIG_NEG, DIG_ONE, DIG_TWO} <= {1'b0, sreg_n[WORD_W-1], 1'b0};
      end else begin
        {DIG_NEG, DIG_ONE, DIG_TWO} <= 3'b000;
      end
    end
  end
endmodule
